period_meter: RTL

Measuring end of the clock/periodic-signal chain. The divider and oscillator blocks produce a periodic signal from a programmed divisor; this block takes an arbitrary periodic input, synchronises it to `clk`, and reports its period and high time as `clk` cycle counts. The results feed divider self-check, duty-cycle verification and oscillator characterisation.

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 34 +++
 rtl/period_meter.sv | 108 ++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared state encoding and default sizing for the period meter.
package period_meter_pkg;

  localparam int DEF_W           = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input plus rising-edge detect
// on the synchronised level.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_d,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_s_prev <= w_s;
    end
  end

  assign o_s    = w_s;
  assign o_rise = w_s & ~r_s_prev;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous periodic input, in clk
// cycles, between consecutive rising edges; flags loss of signal on counter saturation.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_sig_in,
  output logic [W-1:0] o_period,
  output logic [W-1:0] o_high_time,
  output logic         o_valid,
  output logic         o_no_signal
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic         w_s;
  logic         w_rise;

  state_t       r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_hcnt;
  logic [W-1:0] r_period;
  logic [W-1:0] r_high_time;
  logic         r_valid;
  logic         r_no_signal;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_clear(i_clear),
    .i_d    (i_sig_in),
    .o_s    (w_s),
    .o_rise (w_rise)
  );

  // Disable takes priority over everything; a rise coinciding with saturation is a real measurement.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_no_signal <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_cnt   <= '0;
            r_hcnt  <= '0;
          end
          ST_ARM: begin
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_cnt   <= CNT_ONE;
              r_hcnt  <= CNT_ONE;
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              r_period    <= r_cnt;
              r_high_time <= r_hcnt;
              r_valid     <= 1'b1;
              r_no_signal <= 1'b0;
              r_cnt       <= CNT_ONE;
              r_hcnt      <= CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
              r_no_signal <= 1'b1;
              r_state     <= ST_ARM;
              r_cnt       <= '0;
              r_hcnt      <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (w_s) begin
                r_hcnt <= r_hcnt + CNT_ONE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high_time;
  assign o_valid     = r_valid;
  assign o_no_signal = r_no_signal;

endmodule
